// File: rtl/iterative_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation select,
// FSM states and the default datapath width.
package iterative_muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_MOD  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier and restoring divider registers, advanced one iteration
// per enabled cycle. Exposes next-iteration values so the final step can be captured.
module muldiv_datapath
    import iterative_muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] mul_nxt,
    output logic [WIDTH-1:0] quo_nxt,
    output logic [WIDTH-1:0] rem_nxt
);

    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   dvsr_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   rem_r;
    logic [2*WIDTH-1:0] prod_r;

    logic [WIDTH:0]     psum_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     shift_s;
    logic [WIDTH-1:0]   diff_s;
    logic               ge_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    // One multiply iteration and one restoring-divide iteration
    always_comb begin
        psum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        if (prod_r[0]) begin
            prod_s = {psum_s, prod_r[WIDTH-1:1]};
        end else begin
            prod_s = {1'b0, prod_r[2*WIDTH-1:1]};
        end
        // Remainder stays below the divisor, so the low WIDTH bits of the difference suffice
        shift_s = {rem_r, quo_r[WIDTH-1]};
        ge_s    = (shift_s >= {1'b0, dvsr_r});
        diff_s  = shift_s[WIDTH-1:0] - dvsr_r;
        if (ge_s) begin
            rem_s = diff_s;
            quo_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_s = shift_s[WIDTH-1:0];
            quo_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    assign mul_nxt = prod_s[WIDTH-1:0];
    assign quo_nxt = quo_s;
    assign rem_nxt = rem_s;

    // Operand capture on load, iteration on step
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcand_r <= {WIDTH{1'b0}};
            dvsr_r  <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            prod_r  <= {(2*WIDTH){1'b0}};
        end else if (load) begin
            mcand_r <= opa;
            dvsr_r  <= opb;
            quo_r   <= opa;
            rem_r   <= {WIDTH{1'b0}};
            prod_r  <= {{WIDTH{1'b0}}, opb};
        end else if (step) begin
            prod_r  <= prod_s;
            quo_r   <= quo_s;
            rem_r   <= rem_s;
        end
    end

endmodule

// File: rtl/iterative_muldiv.sv
// Multi-cycle unsigned mul/div/mod unit: IDLE/RUN/DONE control with an iteration
// counter around muldiv_datapath; result and flags are registered at done.
module iterative_muldiv
    import iterative_muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       opSel,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             divByZero
);

    state_e           state_r, state_s;
    op_e              op_r, op_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic             dbz_r, dbz_s;
    logic             busy_r, done_r;
    logic             load_s, step_s;
    logic             bypass_s, byp_dbz_s;
    logic [WIDTH-1:0] byp_res_s;
    logic [WIDTH-1:0] mul_nxt_s, quo_nxt_s, rem_nxt_s;

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clock   (clock),
        .reset   (reset),
        .load    (load_s),
        .step    (step_s),
        .opa     (dataA),
        .opb     (dataB2),
        .mul_nxt (mul_nxt_s),
        .quo_nxt (quo_nxt_s),
        .rem_nxt (rem_nxt_s)
    );

    // Ops that finish without iterating: divide/modulo by zero and the reserved code
    always_comb begin
        bypass_s  = 1'b0;
        byp_dbz_s = 1'b0;
        byp_res_s = {WIDTH{1'b0}};
        case (op_e'(opSel))
            OP_DIV: begin
                bypass_s  = (dataB2 == {WIDTH{1'b0}});
                byp_dbz_s = bypass_s;
                byp_res_s = {WIDTH{1'b1}};
            end
            OP_MOD: begin
                bypass_s  = (dataB2 == {WIDTH{1'b0}});
                byp_dbz_s = bypass_s;
                byp_res_s = dataA;
            end
            OP_RSVD: begin
                bypass_s  = 1'b1;
                byp_dbz_s = 1'b0;
                byp_res_s = {WIDTH{1'b0}};
            end
            default: begin
                bypass_s  = 1'b0;
                byp_dbz_s = 1'b0;
                byp_res_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Next-state, counter and result selection
    always_comb begin
        state_s  = state_r;
        op_s     = op_r;
        cnt_s    = cnt_r;
        result_s = result_r;
        dbz_s    = dbz_r;
        load_s   = 1'b0;
        step_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s = 1'b1;
                    op_s   = op_e'(opSel);
                    cnt_s  = {CNT_W{1'b0}};
                    if (bypass_s) begin
                        state_s  = ST_DONE;
                        result_s = byp_res_s;
                        dbz_s    = byp_dbz_s;
                    end else begin
                        state_s  = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                // The last iteration's value is taken straight from the datapath's next value
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_s = ST_DONE;
                    dbz_s   = 1'b0;
                    case (op_r)
                        OP_MUL:  result_s = mul_nxt_s;
                        OP_DIV:  result_s = quo_nxt_s;
                        OP_MOD:  result_s = rem_nxt_s;
                        default: result_s = {WIDTH{1'b0}};
                    endcase
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control state and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            op_r     <= OP_MUL;
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {WIDTH{1'b0}};
            dbz_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            op_r     <= op_s;
            cnt_r    <= cnt_s;
            result_r <= result_s;
            dbz_r    <= dbz_s;
            busy_r   <= (state_s == ST_RUN);
            done_r   <= (state_s == ST_DONE);
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign divByZero = dbz_r;
    assign zero      = (result_r == {WIDTH{1'b0}});
    assign negative  = result_r[WIDTH-1];

endmodule

// File: tb/tb_iterative_muldiv.sv
// Scoreboard bench for iterative_muldiv: expectations are computed with native
// SystemVerilog arithmetic when a start is driven and compared at done.
module tb_iterative_muldiv;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   opSel = 2'b00;
    logic [W-1:0] dataA = '0;
    logic [W-1:0] dataB2 = '0;
    logic         busy, done, zero, negative, divByZero;
    logic [W-1:0] result;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];

    iterative_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .opSel     (opSel),
        .dataA     (dataA),
        .dataB2    (dataB2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .divByZero (divByZero)
    );

    always #5 clock = ~clock;

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] p;
        e.res = '0;
        e.dbz = 1'b0;
        e.lat = W + 1;
        case (op)
            2'b00: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.res = p[W-1:0];
            end
            2'b01: begin
                if (b == '0) begin e.res = '1; e.dbz = 1'b1; e.lat = 1; end
                else e.res = a / b;
            end
            2'b10: begin
                if (b == '0) begin e.res = a; e.dbz = 1'b1; e.lat = 1; end
                else e.res = a % b;
            end
            default: e.lat = 1;
        endcase
        return e;
    endfunction

    // Called just after a falling edge; start is sampled at the next rising edge (cycle 0).
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        opSel  = op;
        dataA  = a;
        dataB2 = b;
        start  = 1'b1;
        sb.push_back(model(op, a, b));
        @(posedge clock);
        #1;
        start  = 1'b0;
        dataA  = $urandom;
        dataB2 = $urandom;
        opSel  = 2'($urandom);
    endtask

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
        end
    endtask

    task automatic wait_done(input string name, input int pulse_at);
        int   n = 0;
        int   bn = 0;
        bit   got = 1'b0;
        exp_t e;
        while (!got && n < 100) begin
            @(negedge clock);
            n++;
            if (pulse_at > 0 && n == pulse_at) begin
                opSel = 2'b00; dataA = 32'd3; dataB2 = 32'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) got = 1'b1;
            else if (busy === 1'b1) bn++;
        end
        start = 1'b0;
        vectors++;
        if (!got || sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s timeout: no done after %0d cycles, expected one", name, n);
            sb.delete();
            return;
        end
        e = sb.pop_front();
        if (n != e.lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d expected %0d", name, n, e.lat);
        end
        vectors++;
        if (bn != ((e.lat == 1) ? 0 : W)) begin
            miscompares++;
            $display("FAIL %s busy cycles: got %0d expected %0d", name, bn, (e.lat == 1) ? 0 : W);
        end
        chk({name, " result"}, result, e.res);
        chk({name, " divByZero"}, {{(W-1){1'b0}}, divByZero}, {{(W-1){1'b0}}, e.dbz});
        chk({name, " zero"}, {{(W-1){1'b0}}, zero}, {{(W-1){1'b0}}, (e.res == '0)});
        chk({name, " negative"}, {{(W-1){1'b0}}, negative}, {{(W-1){1'b0}}, e.res[W-1]});
        @(negedge clock);
        chk({name, " done pulse"}, {{(W-1){1'b0}}, done}, '0);
        chk({name, " held"}, result, e.res);
    endtask

    task automatic test_reset();
        #7;
        chk("reset busy", {{(W-1){1'b0}}, busy}, '0);
        chk("reset done", {{(W-1){1'b0}}, done}, '0);
        chk("reset result", result, '0);
        chk("reset zero", {{(W-1){1'b0}}, zero}, 32'd1);
        chk("reset negative", {{(W-1){1'b0}}, negative}, '0);
        chk("reset divByZero", {{(W-1){1'b0}}, divByZero}, '0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle busy/done", {{(W-2){1'b0}}, busy, done}, '0);
        end
        chk("idle result", result, '0);
    endtask

    task automatic test_mul();
        issue(2'b00, 32'd7, 32'd6);
        wait_done("mul 7x6", 0);
        issue(2'b00, 32'hFFFF_FFFF, 32'd2);
        wait_done("mul ffffffff x2", 0);
    endtask

    task automatic test_div();
        issue(2'b01, 32'd100, 32'd7);
        wait_done("div 100/7", 0);
        issue(2'b10, 32'd100, 32'd7);
        wait_done("mod 100%7", 0);
        issue(2'b10, 32'd21, 32'd7);
        wait_done("mod 21%7", 0);
    endtask

    task automatic test_bypass();
        issue(2'b01, 32'd5, 32'd0);
        wait_done("div 5/0", 0);
        issue(2'b10, 32'd5, 32'd0);
        wait_done("mod 5/0", 0);
        issue(2'b11, 32'd5, 32'd9);
        wait_done("reserved op", 0);
    endtask

    task automatic test_back_to_back();
        bit extra = 1'b0;
        issue(2'b01, 32'd1000, 32'd13);
        wait_done("div ignore restart", 5);
        issue(2'b00, 32'h1234_5678, 32'h0000_0100);
        wait_done("mul after done", 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done === 1'b1) extra = 1'b1;
        end
        chk("no stray done", {{(W-1){1'b0}}, extra}, '0);
    endtask

    task automatic test_reset_abort();
        bit seen = 1'b0;
        issue(2'b01, 32'd1000, 32'd3);
        repeat (10) @(negedge clock);
        chk("busy before abort", {{(W-1){1'b0}}, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort busy", {{(W-1){1'b0}}, busy}, '0);
        chk("abort result", result, '0);
        chk("abort done", {{(W-1){1'b0}}, done}, '0);
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("abort no done", {{(W-1){1'b0}}, seen}, '0);
        issue(2'b01, 32'd9, 32'd3);
        wait_done("div 9/3", 0);
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 6; i++) begin
            op = 2'($urandom_range(0, 2));
            a  = $urandom;
            b  = (i % 2 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            issue(op, a, b);
            wait_done("random", 0);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_bypass();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
